// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div,
// and reports busy/start so decode can stall dependent MD instructions.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        md_start,
    output logic        md_busy,
    output logic [3:0]  md_cnt,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_rd
);

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    // Handshake: md_start is the single accept strobe; an op is taken only on an
    // edge where md_start is high, and md_busy stays high until HI/LO commit.
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_temp_hi;
    logic [31:0] r_temp_lo;
    logic        r_div0;

    logic               w_is_arith;
    logic               w_is_div;
    logic [63:0]        w_a_sx;
    logic [63:0]        w_b_sx;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_ovf;
    logic [31:0]        w_divisor_u;
    logic [31:0]        w_divisor_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic [3:0]         w_lat;

    assign w_is_arith = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign w_is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign md_start   = w_is_arith && !flush && !r_busy;

    assign w_a_sx   = {{32{A[31]}}, A};
    assign w_b_sx   = {{32{B[31]}}, B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Zero divisor and the signed overflow case are steered to a divide-by-one:
    // the former is discarded at commit, the latter yields exactly 0x80000000 r 0.
    assign w_ovf       = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_divisor_u = (B == 32'd0) ? 32'd1 : B;
    assign w_divisor_s = w_ovf ? 32'd1 : w_divisor_u;
    assign w_quo_s     = $signed(A) / $signed(w_divisor_s);
    assign w_rem_s     = $signed(A) % $signed(w_divisor_s);
    assign w_quo_u     = A / w_divisor_u;
    assign w_rem_u     = A % w_divisor_u;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_lat    = LP_MULT_CNT;
        case (md_op)
            OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
            OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
            OP_DIV:   begin w_res_hi = w_rem_s; w_res_lo = w_quo_s; w_lat = LP_DIV_CNT; end
            OP_DIVU:  begin w_res_hi = w_rem_u; w_res_lo = w_quo_u; w_lat = LP_DIV_CNT; end
            default:  begin w_res_hi = 32'd0; w_res_lo = 32'd0; end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_temp_hi <= 32'd0;
            r_temp_lo <= 32'd0;
            r_div0    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (md_start) begin
                        r_temp_hi <= w_res_hi;
                        r_temp_lo <= w_res_lo;
                        r_div0    <= w_is_div && (B == 32'd0);
                        r_cnt     <= w_lat;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else if (!flush) begin
                        if (md_op == OP_MTHI) r_hi <= A;
                        if (md_op == OP_MTLO) r_lo <= A;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (!r_div0) begin
                            r_hi <= r_temp_hi;
                            r_lo <= r_temp_lo;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md_busy = r_busy;
    assign md_cnt  = r_cnt;
    assign HI      = r_hi;
    assign LO      = r_lo;
    assign md_rd   = (md_op == OP_MFHI) ? r_hi :
                     (md_op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios plus random ops, with a completion
// scoreboard fed by a behavioural HI/LO model.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        flush = 1'b0;
  logic        md_start;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_rd;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .md_op(md_op), .A(A), .B(B), .flush(flush),
    .md_start(md_start), .md_busy(md_busy), .md_cnt(md_cnt),
    .HI(HI), .LO(LO), .md_rd(md_rd)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q entry: {latency[3:0], hi[31:0], lo[31:0]}
  logic [67:0] exp_q[$];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
  bit          pend = 1'b0;
  int          m_end = 0;

  task automatic apply_done(input int upto);
    if (pend && m_end <= upto) begin
      m_hi = p_hi;
      m_lo = p_lo;
      pend = 1'b0;
    end
  endtask

  task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa, sb, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = m_hi;
    lo = m_lo;
    lat = (op == 4'd3 || op == 4'd4) ? 10 : 5;
    case (op)
      4'd1: begin sq = sa * sb; hi = sq[63:32]; lo = sq[31:0]; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      4'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
      4'd4: if (b != 0) begin hi = a % b; lo = a / b; end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit fl);
    int e, lat;
    bit busy, exp_start;
    logic [31:0] rhi, rlo, exp_rd;
    @(negedge clk);
    md_op = op; A = a; B = b; flush = fl;
    #1;
    e = cyc + 1;
    apply_done(cyc);
    busy = (e <= m_end);
    exp_start = (op >= 4'd1 && op <= 4'd4) && !fl && !busy;
    exp_rd = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    check("md_start", {31'd0, md_start}, {31'd0, exp_start});
    check("md_rd", md_rd, exp_rd);
    if (exp_start) begin
      model_result(op, a, b, rhi, rlo, lat);
      exp_q.push_back({4'(lat), rhi, rlo});
      p_hi = rhi; p_lo = rlo; pend = 1'b1;
      m_end = e + lat;
    end else if (!busy && !fl) begin
      if (op == 4'd5) m_hi = a;
      if (op == 4'd6) m_lo = a;
    end
    @(posedge clk);
    #1;
    apply_done(cyc);
    check("busy_after_edge", {31'd0, md_busy}, {31'd0, (e < m_end)});
    check("HI_after_edge", HI, m_hi);
    check("LO_after_edge", LO, m_lo);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc + 1 <= m_end && guard < 40) begin
      issue(4'd0, $urandom, $urandom, 1'b0);
      guard++;
    end
    check("idle_reached", {31'd0, md_busy}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          prev_busy = 1'b0;
  int          run = 0;
  logic [67:0] ent;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
      run = 0;
    end else begin
      if (md_busy) begin
        run++;
        if (exp_q.size() == 0) begin
          check("busy_without_op", {31'd0, md_busy}, 32'd0);
        end else begin
          ent = exp_q[0];
          check("md_cnt", {28'd0, md_cnt}, 32'(int'(ent[67:64]) - run + 1));
        end
      end
      if (prev_busy && !md_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          ent = exp_q.pop_front();
          check("busy_len", 32'(run), {28'd0, ent[67:64]});
          check("done_HI", HI, ent[63:32]);
          check("done_LO", LO, ent[31:0]);
        end
        run = 0;
      end
      prev_busy = md_busy;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_cnt", {28'd0, md_cnt}, 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    reset_n = 1'b1;

    // unsigned multiply
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle();
    check("multu_HI", HI, 32'h0000_0001);
    check("multu_LO", LO, 32'hFFFF_FFFE);

    // signed divide, negative dividend
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    check("div_neg_LO", LO, 32'hFFFF_FFFD);
    check("div_neg_HI", HI, 32'hFFFF_FFFF);

    // overflow, then divide by zero
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    check("div_ovf_LO", LO, 32'h8000_0000);
    check("div_ovf_HI", HI, 32'd0);
    issue(4'd4, 32'h0000_1234, 32'd0, 1'b0);
    wait_idle();
    check("div0_LO", LO, 32'h8000_0000);
    check("div0_HI", HI, 32'd0);

    // mthi/mtlo and read-back; mthi while busy is ignored
    issue(4'd5, 32'h0000_1234, 32'd0, 1'b0);
    issue(4'd6, 32'h0000_5678, 32'd0, 1'b0);
    check("mthi_HI", HI, 32'h0000_1234);
    check("mtlo_LO", LO, 32'h0000_5678);
    issue(4'd7, 32'd0, 32'd0, 1'b0);
    issue(4'd8, 32'd0, 32'd0, 1'b0);
    issue(4'd1, 32'd7, 32'd9, 1'b0);
    issue(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("mthi_busy_HI", HI, 32'h0000_1234);
    issue(4'd7, 32'd0, 32'd0, 1'b0);
    wait_idle();
    check("mult_LO", LO, 32'd63);

    // flush blocks start; flush during a run does not cancel it
    issue(4'd1, 32'd11, 32'd13, 1'b1);
    check("flush_busy", {31'd0, md_busy}, 32'd0);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(4'd0, 32'd0, 32'd0, 1'b1);
    issue(4'd6, 32'd99, 32'd0, 1'b1);
    wait_idle();
    check("flush_run_LO", LO, 32'hFFFF_FFFA);

    // asynchronous reset mid-divide
    issue(4'd3, 32'd1000, 32'd7, 1'b0);
    repeat (3) issue(4'd0, 32'd0, 32'd0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, md_busy}, 32'd0);
    check("arst_cnt", {28'd0, md_cnt}, 32'd0);
    check("arst_HI", HI, 32'd0);
    check("arst_LO", LO, 32'd0);
    exp_q.delete();
    m_hi = 32'd0; m_lo = 32'd0; pend = 1'b0; m_end = 0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    issue(4'd1, 32'd3, 32'd5, 1'b0);
    wait_idle();
    check("post_rst_LO", LO, 32'd15);

    // random traffic, including ops issued while busy
    for (int i = 0; i < 80; i++) begin
      issue(4'($urandom_range(0, 15)), pick_val(), pick_val(), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
